// File: rtl/dmem_responder.sv
// Word-organised data-memory slave with byte-lane stores, extended loads and programmable wait states.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of force-aligning them.

package risc_pkg;
    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;
endpackage

module dmem_responder
    import risc_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_req,
    input  logic [31:0] dmem_addr,
    input  mem_size_t   dmem_size,
    input  logic        dmem_wr_en,
    input  logic [31:0] dmem_wr_data,
    input  logic        dmem_zero_extend,
    output logic        dmem_ready,
    output logic        dmem_rvalid,
    output logic [31:0] dmem_rd_data,
    output logic        dmem_err
);

    localparam int IDXW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [IDXW-1:0] idx_q;
    logic [1:0]      lane_q;
    mem_size_t       size_q;
    logic            wr_q;
    logic [31:0]     wdata_q;
    logic            zext_q;
    logic [31:0]     rd_data_q;
    logic            err_q;
    logic [31:0]     ram_q;

    logic            accept;
    mem_size_t       req_size;
    logic [1:0]      req_lane;
    logic            misalign;
    logic [IDXW-1:0] rd_idx;
    logic [3:0]      be;
    logic [31:0]     wr_word;
    logic [31:0]     ld_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            unused_addr;

    assign unused_addr = ^dmem_addr[31:IDXW+2];
    assign accept      = (state_q == S_IDLE) && dmem_req;

    always_comb begin
        case (dmem_size)
            BYTE:      req_size = BYTE;
            HALF_WORD: req_size = HALF_WORD;
            default:   req_size = WORD;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    always_comb begin
        req_lane = dmem_addr[1:0];
        case (req_size)
            BYTE:      misalign = 1'b0;
            HALF_WORD: misalign = dmem_addr[0];
            default:   misalign = (dmem_addr[1:0] != 2'b00);
        endcase
    end
`else
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            BYTE:      req_lane = dmem_addr[1:0];
            HALF_WORD: req_lane = {dmem_addr[1], 1'b0};
            default:   req_lane = 2'b00;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (dmem_req) begin
                    if (misalign) begin
                        state_d = S_RESP;
                    end else if (LATENCY == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign dmem_ready   = (state_q == S_IDLE);
    assign dmem_rvalid  = (state_q == S_RESP);
    assign dmem_rd_data = rd_data_q;
    assign dmem_err     = err_q;

    always_comb begin
        be      = 4'b1111;
        wr_word = wdata_q;
        case (size_q)
            BYTE: begin
                be      = 4'b0001 << lane_q;
                wr_word = {4{wdata_q[7:0]}};
            end
            HALF_WORD: begin
                be      = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Read port follows the incoming request while idle so the word is ready by the ACCESS edge.
    assign rd_idx = (state_q == S_IDLE) ? dmem_addr[IDXW+1:2] : idx_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_lane [DEPTH];

            always_ff @(posedge clk) begin
                if (reset_n && (state_q == S_ACCESS) && wr_q && be[gi]) begin
                    mem_lane[idx_q] <= wr_word[8*gi +: 8];
                end
                ram_q[8*gi +: 8] <= mem_lane[rd_idx];
            end
        end
    endgenerate

    always_comb begin
        ld_byte = ram_q[{lane_q, 3'b000} +: 8];
        ld_half = lane_q[1] ? ram_q[31:16] : ram_q[15:0];
        case (size_q)
            BYTE:      ld_data = {{24{~zext_q & ld_byte[7]}}, ld_byte};
            HALF_WORD: ld_data = {{16{~zext_q & ld_half[15]}}, ld_half};
            default:   ld_data = ram_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q     <= '0;
            lane_q    <= 2'b00;
            size_q    <= BYTE;
            wr_q      <= 1'b0;
            wdata_q   <= 32'd0;
            zext_q    <= 1'b0;
            rd_data_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                idx_q   <= dmem_addr[IDXW+1:2];
                lane_q  <= req_lane;
                size_q  <= req_size;
                wr_q    <= dmem_wr_en;
                wdata_q <= dmem_wr_data;
                zext_q  <= dmem_zero_extend;
                if (misalign) begin
                    rd_data_q <= 32'd0;
                    err_q     <= 1'b1;
                end
            end
            if (state_q == S_ACCESS) begin
                err_q <= 1'b0;
                if (!wr_q) rd_data_q <= ld_data;
            end
        end
    end

endmodule
